// File: rtl/sort_n_value_pipe.sv
// Fully pipelined odd-even transposition sorter: NUM_IN registered layers, stable, per-vector direction.
// Optional source-index tracking (out_idx) is enabled by defining SORT_N_IDX_TRACK_EN.
module sort_n_value_pipe #(
   parameter int DAT_WDTH = 8,
   parameter int NUM_IN   = 5,
   parameter int IDX_WDTH = $clog2(NUM_IN)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         sw_rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         in_desc,
   input  logic [NUM_IN*DAT_WDTH-1:0]   in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [NUM_IN*DAT_WDTH-1:0]   out_data,
   output logic [DAT_WDTH-1:0]          out_median
`ifdef SORT_N_IDX_TRACK_EN
   ,
   output logic [NUM_IN*IDX_WDTH-1:0]   out_idx
`endif
);

   typedef logic [DAT_WDTH-1:0] dat_t;

   // Index [stage][slot]; src_* is what feeds layer s, dat_d its compare-exchange result.
   dat_t              src_dat [NUM_IN][NUM_IN];
   dat_t              dat_d   [NUM_IN][NUM_IN];
   dat_t              dat_q   [NUM_IN][NUM_IN];
   logic [NUM_IN-1:0] valid_q;
   logic [NUM_IN-2:0] desc_q;
   logic [NUM_IN-1:0] desc_src;
   logic              adv;

`ifdef SORT_N_IDX_TRACK_EN
   typedef logic [IDX_WDTH-1:0] idx_t;
   idx_t              src_idx [NUM_IN][NUM_IN];
   idx_t              idx_d   [NUM_IN][NUM_IN];
   idx_t              idx_q   [NUM_IN][NUM_IN];
`endif

   // Whole pipeline advances or holds together; bubbles are never squeezed out.
   assign out_valid = valid_q[NUM_IN-1];
   assign adv       = ~out_valid | out_ready;
   assign in_ready  = adv;
   assign desc_src  = {desc_q, in_desc};

   for (genvar s = 0; s < NUM_IN; s++) begin : g_stage
      for (genvar k = 0; k < NUM_IN; k++) begin : g_slot
         if (s == 0) begin : g_in
            assign src_dat[s][k] = in_data[k*DAT_WDTH +: DAT_WDTH];
`ifdef SORT_N_IDX_TRACK_EN
            assign src_idx[s][k] = idx_t'(k);
`endif
         end else begin : g_pipe
            assign src_dat[s][k] = dat_q[s-1][k];
`ifdef SORT_N_IDX_TRACK_EN
            assign src_idx[s][k] = idx_q[s-1][k];
`endif
         end
      end
   end

   // NOTE: every combinational output gets a full default before any conditional update, so no latch is inferred.
   always_comb begin
      dat_d = src_dat;
`ifdef SORT_N_IDX_TRACK_EN
      idx_d = src_idx;
`endif
      for (int s = 0; s < NUM_IN; s++) begin
         // Strict compare only: equal samples never cross, which keeps the sort stable.
         for (int p = s % 2; p + 1 < NUM_IN; p += 2) begin
            if (desc_src[s] ? (src_dat[s][p] < src_dat[s][p+1])
                            : (src_dat[s][p] > src_dat[s][p+1])) begin
               dat_d[s][p]   = src_dat[s][p+1];
               dat_d[s][p+1] = src_dat[s][p];
`ifdef SORT_N_IDX_TRACK_EN
               idx_d[s][p]   = src_idx[s][p+1];
               idx_d[s][p+1] = src_idx[s][p];
`endif
            end
         end
      end
   end

   // NOTE: state is updated with non-blocking assignments only, so every stage samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         desc_q  <= '0;
         // NOTE: payload arrays are reset too, so invalid stages never carry X into later compares.
         dat_q   <= '{default: '0};
`ifdef SORT_N_IDX_TRACK_EN
         idx_q   <= '{default: '0};
`endif
      end else if (!sw_rst_n) begin
         valid_q <= '0;
         desc_q  <= '0;
         dat_q   <= '{default: '0};
`ifdef SORT_N_IDX_TRACK_EN
         idx_q   <= '{default: '0};
`endif
      end else if (adv) begin
         valid_q <= {valid_q[NUM_IN-2:0], in_valid & in_ready};
         desc_q  <= desc_src[NUM_IN-2:0];
         dat_q   <= dat_d;
`ifdef SORT_N_IDX_TRACK_EN
         idx_q   <= idx_d;
`endif
      end
   end

   always_comb begin
      out_data = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         out_data[k*DAT_WDTH +: DAT_WDTH] = dat_q[NUM_IN-1][k];
      end
   end

   assign out_median = dat_q[NUM_IN-1][NUM_IN/2];

`ifdef SORT_N_IDX_TRACK_EN
   always_comb begin
      out_idx = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         out_idx[k*IDX_WDTH +: IDX_WDTH] = idx_q[NUM_IN-1][k];
      end
   end
`endif

endmodule
